// File: rtl/sorted_insert_writer.sv
// Insertion writer for an ascending RAM table: shifts larger entries up one slot
// from the top, then writes the new value into the gap. start/done handshake.
module sorted_insert_writer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              rejected
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CMP,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              rej_q, rej_d;

    // State and registered-output register bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            full_q  <= full_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
        end
    end

    // Next-state and next-output decode; each state's outputs appear the cycle after it
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        idx_d   = idx_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rej_d   = rej_q;
        we_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (start) begin
                    if (full_q) begin
                        rej_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rej_d   = 1'b0;
                        val_d   = data_in;
                        idx_d   = count_q;
                        state_d = (count_q == '0) ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                addr_d  = ADDR_W'(idx_q - CNT_W'(1));
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // Strict compare: equal entries stay below, keeping inserts stable
                if (mem_rdata > val_q) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_W'(idx_q);
                    wdata_d = mem_rdata;
                    idx_d   = idx_q - CNT_W'(1);
                    state_d = (idx_q == CNT_W'(1)) ? S_WRITE : S_READ;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(idx_q);
                wdata_d = val_q;
                count_d = count_q + CNT_W'(1);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    done_d = 1'b1;
                end else begin
                    rej_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        full_d = (count_d == CNT_W'(DEPTH));
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign count     = count_q;
    assign full      = full_q;
    assign done      = done_q;
    assign rejected  = rej_q;

endmodule

// File: tb/tb_sorted_insert_writer.sv
// Scoreboard bench for sorted_insert_writer: directed inserts against a
// synchronous-read RAM model; a monitor checks latency/reject/count at each done.
module tb_sorted_insert_writer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              clear;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              rejected;

    sorted_insert_writer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .data_in  (data_in),
        .mem_rdata(mem_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .count    (count),
        .full     (full),
        .done     (done),
        .rejected (rejected)
    );

    always #5 clk = ~clk;

    // Table RAM: write on mem_we, registered read of the presented address
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int we_cnt = 0;
    int last_waddr = -1;
    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= int'(mem_addr);
        end
    end

    int ncheck = 0;
    int nfail  = 0;

    task automatic check(input string name, input int act, input int exp);
        ncheck++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    typedef struct {
        int   lat;
        logic rej;
        int   cnt;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: counts edges since start was first seen, scores each done rise
    initial begin : monitor
        bit   in_txn = 0;
        bit   seen   = 0;
        int   cyc    = 0;
        logic st;
        exp_t e;
        forever begin
            @(posedge clk);
            st = start;
            if (st !== 1'b1) begin
                in_txn = 0;
                seen   = 0;
            end else if (!in_txn) begin
                in_txn = 1;
                seen   = 0;
                cyc    = 0;
            end else begin
                cyc++;
            end
            #1;
            if (in_txn && !seen && done === 1'b1) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", cyc, e.lat);
                    check("rejected", int'(rejected), int'(e.rej));
                    check("count_at_done", int'(count), e.cnt);
                end
            end else if (in_txn && !seen && cyc > 150) begin
                seen = 1;
                check("done_timeout", int'(done), 1);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_insert(input logic [DATA_W-1:0] v, input int lat, input logic rej,
                             input int cnt, input int hold);
        int we0;
        exp_q.push_back('{lat, rej, cnt});
        @(negedge clk);
        start   = 1'b1;
        data_in = v;
        @(negedge clk);
        data_in = ~v;
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clk);
        check("done_seen", int'(done), 1);
        we0 = we_cnt;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("done_held", int'(done), 1);
        end
        if (hold > 0) begin
            check("hold_no_write", we_cnt, we0);
            check("hold_count", int'(count), cnt);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("clear_count", int'(count), 0);
        check("clear_full", int'(full), 0);
    endtask

    initial begin : stim
        int we0;
        reset   = 1'b0;
        start   = 1'b0;
        clear   = 1'b0;
        data_in = '0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_done", int'(done), 0);
        check("rst_rejected", int'(rejected), 0);
        reset = 1'b1;
        @(negedge clk);

        // Insert into empty table
        do_insert(8'h10, 2, 1'b0, 1, 0);
        check("empty_ram0", int'(ram[0]), 'h10);
        check("empty_waddr", last_waddr, 0);

        // 0x30, 0x20, 0x10: one shift then two shifts
        do_clear();
        do_insert(8'h30, 2, 1'b0, 1, 0);
        do_insert(8'h20, 5, 1'b0, 2, 0);
        do_insert(8'h10, 8, 1'b0, 3, 0);
        check("sort_ram0", int'(ram[0]), 'h10);
        check("sort_ram1", int'(ram[1]), 'h20);
        check("sort_ram2", int'(ram[2]), 'h30);

        // Duplicate stops the shift and lands above its equal
        do_clear();
        do_insert(8'h10, 2, 1'b0, 1, 0);
        do_insert(8'h20, 5, 1'b0, 2, 0);
        do_insert(8'h20, 5, 1'b0, 3, 0);
        check("dup_waddr", last_waddr, 2);
        check("dup_ram0", int'(ram[0]), 'h10);
        check("dup_ram1", int'(ram[1]), 'h20);
        check("dup_ram2", int'(ram[2]), 'h20);

        // Fill to capacity with ascending values, then a rejected insert
        do_clear();
        for (int i = 0; i < int'(DEPTH); i++)
            do_insert(DATA_W'(i * 4 + 2), (i == 0) ? 2 : 5, 1'b0, i + 1, 0);
        check("full_flag", int'(full), 1);
        check("full_ram31", int'(ram[31]), 31 * 4 + 2);
        we0 = we_cnt;
        do_insert(8'h00, 1, 1'b1, int'(DEPTH), 0);
        check("reject_no_write", we_cnt, we0);
        check("reject_count", int'(count), int'(DEPTH));
        check("reject_ram0", int'(ram[0]), 2);
        do_clear();

        // Start held well past done: no second insert
        do_insert(8'h55, 2, 1'b0, 1, 10);
        check("hold_ram0", int'(ram[0]), 'h55);

        // start and clear together: clear wins, insert follows a cycle later
        exp_q.push_back('{3, 1'b0, 1});
        @(negedge clk);
        start   = 1'b1;
        clear   = 1'b1;
        data_in = 8'h66;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clk);
        check("clr_start_done", int'(done), 1);
        start = 1'b0;
        @(negedge clk);
        check("clr_start_count", int'(count), 1);
        check("clr_start_ram0", int'(ram[0]), 'h66);

        // Reset during WAIT of a shifting insert
        do_insert(8'h70, 5, 1'b0, 2, 0);
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'h01;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("abort_addr", int'(mem_addr), 0);
        check("abort_wdata", int'(mem_wdata), 0);
        check("abort_we", int'(mem_we), 0);
        check("abort_count", int'(count), 0);
        check("abort_done", int'(done), 0);
        check("abort_rejected", int'(rejected), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_abort_count", int'(count), 0);
        do_insert(8'h42, 2, 1'b0, 1, 0);
        check("post_abort_waddr", last_waddr, 0);
        check("post_abort_ram0", int'(ram[0]), 'h42);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
